// File: rtl/tournament_pkg.sv
// Shared types and helpers for the tournament predictor tables.
//   ctr_t          : 2-bit saturating counter stored in every table entry
//   sched_state_e  : update-scheduler FSM states
//   CTR_INIT       : value written to every entry by the initialisation walk
//   ctr_sat_update : saturating increment/decrement of a counter
package tournament_pkg;

    typedef logic [1:0] ctr_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_MOD,
        ST_WR
    } sched_state_e;

    localparam ctr_t CTR_INIT = 2'b10;

    // Taken moves toward 3, not-taken toward 0; both ends stick.
    function automatic ctr_t ctr_sat_update(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/resolve_fifo.sv
// Small FIFO buffering resolved branches until the table port is free.
//   clock, reset      : clock, asynchronous active-low reset
//   flush             : synchronous empty; wins over a same-cycle push/pop
//   push, push_data   : write an entry (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   pop_data          : head entry, valid whenever !empty
//   full, empty       : occupancy flags
// DEPTH must be a power of two; the pointers carry one extra wrap bit so
// that full and empty are distinguishable when the low bits match.
module resolve_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, and leaving it unreset keeps it plain RAM/flops.
    always_ff @(posedge clock) begin
        if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tournament_update_sched.sv
// Shares the single read/write port of one tournament-predictor counter
// table between front-end lookups (always win) and back-end training
// updates (read-modify-write from a resolve FIFO). Also runs the
// initialisation walk after reset or clear_i.
//   clock, reset        : clock, asynchronous active-low reset
//   lookup_valid_i/idx_i: front-end read request; lookup_grant_o = owns port
//   resolve_valid_i/... : resolved branch to train; resolve_ready_o = !full
//   clear_i             : flush FIFO, drop any RMW, restart the init walk
//   busy_o              : init walk, queued updates or RMW in progress
//   tbl_*               : table port; tbl_rdata_i valid the cycle after a read
module tournament_update_sched
    import tournament_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lookup_valid_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_grant_o,
    input  logic             resolve_valid_i,
    output logic             resolve_ready_o,
    input  logic [IDX_W-1:0] resolve_idx_i,
    input  logic             resolve_taken_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic             tbl_en_o,
    output logic             tbl_we_o,
    output logic [IDX_W-1:0] tbl_addr_o,
    output ctr_t             tbl_wdata_o,
    input  ctr_t             tbl_rdata_i
);

    localparam int ENT_W = IDX_W + 1;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             taken_q;
    ctr_t             ctr_q;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0] fifo_head;
    logic             serve_lookup;

    // A resolve offered together with clear_i is discarded by the flush.
    assign fifo_push       = resolve_valid_i && resolve_ready_o && !clear_i;
    assign resolve_ready_o = reset && !fifo_full;
    assign busy_o          = !reset || (state_q != ST_IDLE) || !fifo_empty;

    resolve_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (clear_i),
        .push      (fifo_push),
        .push_data ({resolve_idx_i, resolve_taken_i}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        fifo_pop       = 1'b0;
        serve_lookup   = 1'b0;
        lookup_grant_o = 1'b0;
        tbl_en_o       = 1'b0;
        tbl_we_o       = 1'b0;
        tbl_addr_o     = '0;
        tbl_wdata_o    = '0;

        unique case (state_q)
            ST_INIT: begin
                tbl_en_o    = 1'b1;
                tbl_we_o    = 1'b1;
                tbl_addr_o  = init_cnt_q;
                tbl_wdata_o = CTR_INIT;
                if (init_cnt_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (lookup_valid_i) begin
                    serve_lookup = 1'b1;
                end else if (!fifo_empty) begin
                    tbl_en_o   = 1'b1;
                    tbl_addr_o = fifo_head[ENT_W-1:1];
                    fifo_pop   = 1'b1;
                    state_d    = ST_MOD;
                end
            end
            ST_MOD: begin
                // Read data is being captured; the port itself is free.
                serve_lookup = lookup_valid_i;
                state_d      = ST_WR;
            end
            ST_WR: begin
                if (lookup_valid_i) begin
                    serve_lookup = 1'b1;
                end else begin
                    // A clear in this cycle drops the pending write.
                    if (!clear_i) begin
                        tbl_en_o    = 1'b1;
                        tbl_we_o    = 1'b1;
                        tbl_addr_o  = idx_q;
                        tbl_wdata_o = ctr_sat_update(ctr_q, taken_q);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (serve_lookup) begin
            lookup_grant_o = 1'b1;
            tbl_en_o       = 1'b1;
            tbl_we_o       = 1'b0;
            tbl_addr_o     = lookup_idx_i;
        end

        if (clear_i) state_d = ST_INIT;

        // Outputs are held quiet while reset is asserted.
        if (!reset) begin
            fifo_pop       = 1'b0;
            lookup_grant_o = 1'b0;
            tbl_en_o       = 1'b0;
            tbl_we_o       = 1'b0;
            tbl_addr_o     = '0;
            tbl_wdata_o    = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            idx_q      <= '0;
            taken_q    <= 1'b0;
            ctr_q      <= '0;
        end else begin
            state_q <= state_d;
            // The walk counter wraps back to 0 on its last entry, ready for
            // the next walk.
            if (clear_i)                 init_cnt_q <= '0;
            else if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + IDX_W'(1);
            if (fifo_pop) begin
                idx_q   <= fifo_head[ENT_W-1:1];
                taken_q <= fifo_head[0];
            end
            if (state_q == ST_MOD) ctr_q <= tbl_rdata_i;
        end
    end

endmodule

// File: tb/tb_tournament_update_sched.sv
// Self-checking bench for tournament_update_sched (IDX_W=4, DEPTH=4).
// A behavioural table/queue model runs on every falling edge and predicts
// the port, grant, ready and busy outputs; directed sections pin the model
// with hand-computed literal expectations, then randomized traffic follows.
module tb_tournament_update_sched;

    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int N     = 1 << IDX_W;

    logic             clock;
    logic             reset;
    logic             lookup_valid_i;
    logic [IDX_W-1:0] lookup_idx_i;
    logic             lookup_grant_o;
    logic             resolve_valid_i;
    logic             resolve_ready_o;
    logic [IDX_W-1:0] resolve_idx_i;
    logic             resolve_taken_i;
    logic             clear_i;
    logic             busy_o;
    logic             tbl_en_o;
    logic             tbl_we_o;
    logic [IDX_W-1:0] tbl_addr_o;
    logic [1:0]       tbl_wdata_o;
    logic [1:0]       tbl_rdata_i;

    tournament_update_sched #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_idx_i    (lookup_idx_i),
        .lookup_grant_o  (lookup_grant_o),
        .resolve_valid_i (resolve_valid_i),
        .resolve_ready_o (resolve_ready_o),
        .resolve_idx_i   (resolve_idx_i),
        .resolve_taken_i (resolve_taken_i),
        .clear_i         (clear_i),
        .busy_o          (busy_o),
        .tbl_en_o        (tbl_en_o),
        .tbl_we_o        (tbl_we_o),
        .tbl_addr_o      (tbl_addr_o),
        .tbl_wdata_o     (tbl_wdata_o),
        .tbl_rdata_i     (tbl_rdata_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // The counter table itself: single port, read data one cycle later.
    logic [1:0] mem [N];
    always @(posedge clock) begin
        if (tbl_en_o) begin
            if (tbl_we_o) mem[tbl_addr_o] <= tbl_wdata_o;
            else          tbl_rdata_i     <= mem[tbl_addr_o];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int c, input bit taken);
        if (taken) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int idx;
        bit tk;
    } res_t;

    res_t m_q[$];          // accepted, not yet read
    bit   m_init;
    int   m_init_addr;
    bit   m_fl;            // one update read issued, write pending
    res_t m_fl_e;
    int   m_fl_age;        // cycles since its read
    int   exp_tbl [N];

    always @(negedge clock) begin : model
        bit rd, wr, pushed, e_en, e_we, e_grant;
        int e_addr, e_wdata;
        if (!reset) begin
            m_init      = 1'b1;
            m_init_addr = 0;
            m_q.delete();
            m_fl        = 1'b0;
        end else begin
            // An update read happens whenever the table is initialised, no
            // update is outstanding, something is queued and no lookup asks.
            rd      = !m_init && !m_fl && (m_q.size() > 0) && !lookup_valid_i;
            // Its write needs one capture cycle and then any lookup-free cycle.
            wr      = m_fl && (m_fl_age >= 2) && !lookup_valid_i && !clear_i;
            e_grant = lookup_valid_i && !m_init;
            e_addr  = 0;
            e_wdata = 0;
            if (m_init) begin
                e_en = 1; e_we = 1; e_addr = m_init_addr; e_wdata = 2;
            end else if (e_grant) begin
                e_en = 1; e_we = 0; e_addr = int'(lookup_idx_i);
            end else if (rd) begin
                e_en = 1; e_we = 0; e_addr = m_q[0].idx;
            end else if (wr) begin
                e_en = 1; e_we = 1; e_addr = m_fl_e.idx;
                e_wdata = sat(exp_tbl[m_fl_e.idx], m_fl_e.tk);
            end else begin
                e_en = 0; e_we = 0;
            end

            check("m_grant", lookup_grant_o, e_grant);
            check("m_ready", resolve_ready_o, m_q.size() < DEPTH);
            check("m_busy",  busy_o, m_init || (m_q.size() > 0) || m_fl);
            check("m_en",    tbl_en_o, e_en);
            check("m_we",    tbl_we_o, e_we);
            if (e_en) check("m_addr",  tbl_addr_o, e_addr);
            if (e_we) check("m_wdata", tbl_wdata_o, e_wdata);

            pushed = resolve_valid_i && (m_q.size() < DEPTH);
            if (clear_i) begin
                m_init      = 1'b1;
                m_init_addr = 0;
                m_q.delete();
                m_fl        = 1'b0;
            end else begin
                if (m_init) begin
                    m_init_addr++;
                    if (m_init_addr == N) begin
                        m_init = 1'b0;
                        for (int i = 0; i < N; i++) exp_tbl[i] = 2;
                    end
                end
                if (wr) begin
                    exp_tbl[m_fl_e.idx] = e_wdata;
                    m_fl = 1'b0;
                end else if (m_fl) begin
                    m_fl_age++;
                end
                if (rd) begin
                    m_fl     = 1'b1;
                    m_fl_e   = m_q.pop_front();
                    m_fl_age = 1;
                end
                if (pushed) m_q.push_back('{idx: int'(resolve_idx_i), tk: resolve_taken_i});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_valid_i  = 1'b0;
        lookup_idx_i    = '0;
        resolve_valid_i = 1'b0;
        resolve_idx_i   = '0;
        resolve_taken_i = 1'b0;
        clear_i         = 1'b0;
    endtask

    // One uncontended update: accept at t, read t+1, capture t+2, write t+3.
    task automatic do_update(input int idx, input bit tk, input int exp_w);
        resolve_valid_i = 1'b1;
        resolve_idx_i   = IDX_W'(idx);
        resolve_taken_i = tk;
        @(negedge clock);
        check("upd_ready", resolve_ready_o, 1);
        next();
        resolve_valid_i = 1'b0;
        @(negedge clock);
        check("upd_read_en", tbl_en_o, 1);
        check("upd_read_we", tbl_we_o, 0);
        check("upd_read_addr", tbl_addr_o, idx);
        next();
        @(negedge clock);
        check("upd_mod_en", tbl_en_o, 0);
        next();
        @(negedge clock);
        check("upd_write_we", tbl_we_o, 1);
        check("upd_write_addr", tbl_addr_o, idx);
        check("upd_write_data", tbl_wdata_o, exp_w);
        next();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clock);
        while (busy_o && k < budget) begin
            next();
            @(negedge clock);
            k++;
        end
        check("drain_idle", busy_o, 0);
        next();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        int wlog[$];
        reset = 1'b0;
        idle_inputs();
        lookup_valid_i = 1'b1;

        // Reset asserted: outputs forced quiet.
        repeat (2) @(negedge clock);
        check("rst_en", tbl_en_o, 0);
        check("rst_we", tbl_we_o, 0);
        check("rst_addr", tbl_addr_o, 0);
        check("rst_wdata", tbl_wdata_o, 0);
        check("rst_grant", lookup_grant_o, 0);
        check("rst_ready", resolve_ready_o, 0);
        check("rst_busy", busy_o, 1);

        // Reset walk: 16 writes of 2'b10 to 0..15, grant held low.
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            check("walk_we", tbl_we_o, 1);
            check("walk_addr", tbl_addr_o, i);
            check("walk_data", tbl_wdata_o, 2);
            check("walk_grant", lookup_grant_o, 0);
            next();
        end
        @(negedge clock);
        check("walk_done_grant", lookup_grant_o, 1);
        next();
        lookup_valid_i = 1'b0;
        @(negedge clock);
        check("walk_done_busy", busy_o, 0);
        next();

        // Single updates on entry 5, including both saturation ends.
        do_update(5, 1'b1, 3);
        do_update(5, 1'b1, 3);
        do_update(5, 1'b0, 2);
        do_update(5, 1'b0, 1);
        do_update(5, 1'b0, 0);
        do_update(5, 1'b0, 0);

        // Lookup priority in WR: (7,N) on entry 7 = 2 must write 1 eventually.
        resolve_valid_i = 1'b1;
        resolve_idx_i   = 4'd7;
        resolve_taken_i = 1'b0;
        next();
        resolve_valid_i = 1'b0;
        next();
        next();
        for (int i = 0; i < 4; i++) begin
            lookup_valid_i = 1'b1;
            lookup_idx_i   = IDX_W'(i + 9);
            @(negedge clock);
            check("prio_grant", lookup_grant_o, 1);
            check("prio_we", tbl_we_o, 0);
            check("prio_addr", tbl_addr_o, i + 9);
            next();
        end
        lookup_valid_i = 1'b0;
        @(negedge clock);
        check("prio_write_we", tbl_we_o, 1);
        check("prio_write_addr", tbl_addr_o, 7);
        check("prio_write_data", tbl_wdata_o, 1);
        next();

        // Back-to-back same index: entry 7 = 1, two taken -> 2 then 3.
        resolve_valid_i = 1'b1;
        resolve_idx_i   = 4'd7;
        resolve_taken_i = 1'b1;
        next();
        next();
        resolve_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (tbl_en_o && tbl_we_o) begin
                check("b2b_addr", tbl_addr_o, 7);
                wlog.push_back(int'(tbl_wdata_o));
            end
            next();
        end
        check("b2b_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("b2b_first", wlog[0], 2);
            check("b2b_second", wlog[1], 3);
        end

        // FIFO full while lookups block draining.
        lookup_valid_i = 1'b1;
        lookup_idx_i   = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            resolve_valid_i = 1'b1;
            resolve_idx_i   = IDX_W'(i + 1);
            resolve_taken_i = 1'b1;
            @(negedge clock);
            check("full_fill_ready", resolve_ready_o, 1);
            next();
        end
        resolve_idx_i = 4'd9;
        @(negedge clock);
        check("full_ready_low", resolve_ready_o, 0);
        next();
        resolve_valid_i = 1'b0;
        lookup_valid_i  = 1'b0;
        @(negedge clock);
        check("full_pop_ready", resolve_ready_o, 0);
        check("full_pop_addr", tbl_addr_o, 1);
        check("full_pop_we", tbl_we_o, 0);
        next();
        @(negedge clock);
        check("full_after_pop_ready", resolve_ready_o, 1);
        next();
        wait_idle(60);

        // Clear mid-RMW with two entries still queued.
        lookup_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resolve_valid_i = 1'b1;
            resolve_idx_i   = IDX_W'(i + 10);
            resolve_taken_i = 1'b0;
            next();
        end
        resolve_valid_i = 1'b0;
        lookup_valid_i  = 1'b0;
        @(negedge clock);
        check("clr_read_addr", tbl_addr_o, 10);
        next();
        clear_i = 1'b1;
        @(negedge clock);
        check("clr_busy", busy_o, 1);
        check("clr_mod_we", tbl_we_o, 0);
        next();
        clear_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            check("clr_walk_we", tbl_we_o, 1);
            check("clr_walk_addr", tbl_addr_o, i);
            check("clr_walk_data", tbl_wdata_o, 2);
            check("clr_walk_busy", busy_o, 1);
            next();
        end
        @(negedge clock);
        check("clr_end_busy", busy_o, 0);
        check("clr_end_ready", resolve_ready_o, 1);
        next();

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            lookup_valid_i  = ($urandom_range(0, 9) < 4);
            lookup_idx_i    = IDX_W'($urandom_range(0, N - 1));
            resolve_valid_i = $urandom_range(0, 1) == 1;
            resolve_idx_i   = IDX_W'($urandom_range(0, N - 1));
            resolve_taken_i = $urandom_range(0, 1) == 1;
            clear_i         = ($urandom_range(0, 499) == 0);
            next();
        end
        idle_inputs();
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
